top_k_sorter: RTL

- Downstream stage of the packet parser.
- Consumes the parser's 33-bit word stream (bit 32 = tlast, bits 31:0 = unsigned value).
- For each packet, keeps the K largest values in a sorted register array.
- On the packet's tlast word it stops accepting input and emits the K (or fewer) winners in descending order as a 33-bit stream, with tlast on the final result.

---
 rtl/top_k_sorter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/top_k_sorter.sv
// top_k_sorter: keeps the K largest values of each packet in a sorted
// register array and emits them in descending order after the tlast word.
module top_k_sorter #(
  parameter int K      = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   s_TDATA,
  input  logic              s_TVALID,
  output logic              s_TREADY,
  output logic [DATA_W:0]   m_TDATA,
  output logic              m_TVALID,
  input  logic              m_TREADY,
  output logic              busy
);

  // Handshakes: a word moves on a channel only in a cycle where both VALID and
  // READY are high at posedge clk; a VALID source holds its data until then.

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t              state_q, state_d;
  logic                s_tready_q, s_tready_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W:0]     m_tdata_q, m_tdata_d;
  logic                busy_q, busy_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   val_q [K];
  logic [DATA_W-1:0]   val_d [K];
  logic                vld_q [K];
  logic                vld_d [K];

  logic [DATA_W-1:0]   in_val;
  logic                in_last;
  logic                take;
  logic                gt      [K];
  logic                prev_gt [K];
  logic [DATA_W-1:0]   ins_val [K];
  logic                ins_vld [K];
  logic                last_at [K];
  logic [IW-1:0]       nxt;
  logic [DATA_W-1:0]   nxt_val;
  logic                nxt_last;

  assign s_TREADY = s_tready_q;
  assign m_TVALID = m_tvalid_q;
  assign m_TDATA  = m_tdata_q;
  assign busy     = busy_q;

  // Next-state logic: parallel compare/shift insertion in ACCUM, indexed readout in EMIT.
  always_comb begin
    state_d    = state_q;
    s_tready_d = s_tready_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    busy_d     = busy_q;
    idx_d      = idx_q;
    for (int i = 0; i < K; i++) begin
      val_d[i] = val_q[i];
      vld_d[i] = vld_q[i];
    end

    in_val  = s_TDATA[DATA_W-1:0];
    in_last = s_TDATA[DATA_W];
    take    = (state_q == ACCUM) && s_tready_q && s_TVALID;

    // gt[i] is monotone (0..0 1..1) because valid entries are sorted and
    // contiguous; the insertion point is its first set bit. Using strict '<'
    // places a new value after existing equal ones.
    for (int i = 0; i < K; i++) gt[i] = !vld_q[i] || (val_q[i] < in_val);
    prev_gt[0] = 1'b0;
    for (int i = 1; i < K; i++) prev_gt[i] = gt[i-1];

    for (int i = 0; i < K; i++) begin
      ins_val[i] = val_q[i];
      ins_vld[i] = vld_q[i];
      if (gt[i] && !prev_gt[i]) begin
        ins_val[i] = in_val;
        ins_vld[i] = 1'b1;
      end
    end
    for (int i = 1; i < K; i++) begin
      if (gt[i] && prev_gt[i]) begin
        ins_val[i] = val_q[i-1];
        ins_vld[i] = vld_q[i-1];
      end
    end

    // An entry is the final result when it is the last slot or its successor is empty.
    for (int i = 0; i < K - 1; i++) last_at[i] = !vld_q[i+1];
    last_at[K-1] = 1'b1;

    nxt      = idx_q + 1'b1;
    nxt_val  = '0;
    nxt_last = 1'b1;
    for (int i = 0; i < K; i++) begin
      if (IW'(i) == nxt) begin
        nxt_val  = val_q[i];
        nxt_last = last_at[i];
      end
    end

    if (state_q == ACCUM) begin
      if (take) begin
        busy_d = 1'b1;
        for (int i = 0; i < K; i++) begin
          val_d[i] = ins_val[i];
          vld_d[i] = ins_vld[i];
        end
        if (in_last) begin
          // Entry 0 is always valid after any insert, so the first result is ready now.
          state_d    = EMIT;
          s_tready_d = 1'b0;
          m_tvalid_d = 1'b1;
          idx_d      = '0;
          m_tdata_d  = {!ins_vld[1], ins_val[0]};
        end
      end
    end else begin
      if (m_tvalid_q && m_TREADY) begin
        if (m_tdata_q[DATA_W]) begin
          state_d    = ACCUM;
          s_tready_d = 1'b1;
          m_tvalid_d = 1'b0;
          m_tdata_d  = '0;
          busy_d     = 1'b0;
          idx_d      = '0;
          for (int i = 0; i < K; i++) vld_d[i] = 1'b0;
        end else begin
          idx_d     = nxt;
          m_tdata_d = {nxt_last, nxt_val};
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      for (int i = 0; i < K; i++) begin
        val_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      s_tready_q <= (state_d == ACCUM) ? s_tready_d | (state_q == ACCUM) : s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      for (int i = 0; i < K; i++) begin
        val_q[i] <= val_d[i];
        vld_q[i] <= vld_d[i];
      end
    end
  end

endmodule
